// File: rtl/fifo_pkg.sv
// Shared definitions for the parameterised synchronous FIFO.
// Provides the read-mode encoding, the occupancy counter width helper
// and parameter legality helpers used for elaboration-time checks.
package fifo_pkg;

  typedef enum logic {
    FIFO_MODE_STD  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

  // Occupancy has to represent 0..depth inclusive, hence one extra bit.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit thresh_ok(input int thresh, input int depth);
    return (thresh >= 0) && (thresh <= depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from the array)
// Contents are intentionally not reset.
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO using all FIFO_DEPTH entries.
// Ports:
//   clk, reset_n            - clock (rising edge), async active-low reset
//   write_en, din           - push request and data
//   read_en                 - std mode: pop request; FWFT: head acknowledge
//   dout, dout_valid        - read data and its qualifier
//   fifo_full, fifo_empty   - level == FIFO_DEPTH / level == 0
//   almost_full/empty       - level >= AF_THRESH / level <= AE_THRESH
//   level                   - current occupancy, 0..FIFO_DEPTH
//   overflow, underflow     - sticky error flags
//   clear_err               - synchronous clear of the error flags
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              write_en,
  input  logic [FIFO_WIDTH-1:0]             din,
  input  logic                              read_en,
  output logic [FIFO_WIDTH-1:0]             dout,
  output logic                              dout_valid,
  output logic                              fifo_full,
  output logic                              fifo_empty,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic [level_width(FIFO_DEPTH)-1:0] level,
  output logic                              overflow,
  output logic                              underflow,
  input  logic                              clear_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = level_width(FIFO_DEPTH);

  if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: FIFO_DEPTH must be a power of two >= 2");
  end
  if (!thresh_ok(AF_THRESH, FIFO_DEPTH) || !thresh_ok(AE_THRESH, FIFO_DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_param: AF_THRESH/AE_THRESH must lie in 0..FIFO_DEPTH");
  end

  logic [PW-1:0]         wptr, rptr;
  logic [LW-1:0]         lvl;
  logic [FIFO_WIDTH-1:0] rd_data;
  logic                  wr_ok, rd_ok;
  logic                  ovf_set, unf_set;
  logic                  ovf_q, unf_q;

  // Status is purely a function of the registered occupancy.
  always_comb begin
    fifo_full    = (lvl == LW'(FIFO_DEPTH));
    fifo_empty   = (lvl == '0);
    almost_full  = (int'(lvl) >= AF_THRESH);
    almost_empty = (int'(lvl) <= AE_THRESH);
  end

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  always_comb begin
    rd_ok   = read_en && !fifo_empty;
    wr_ok   = write_en && (!fifo_full || rd_ok);
    ovf_set = write_en && !wr_ok;
    unf_set = read_en && fifo_empty;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      lvl   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + PW'(1);
      if (rd_ok) rptr <= rptr + PW'(1);
      if (wr_ok && !rd_ok)      lvl <= lvl + LW'(1);
      else if (rd_ok && !wr_ok) lvl <= lvl - LW'(1);
      // A new error in the same cycle as clear_err keeps the flag set.
      if (ovf_set)        ovf_q <= 1'b1;
      else if (clear_err) ovf_q <= 1'b0;
      if (unf_set)        unf_q <= 1'b1;
      else if (clear_err) unf_q <= 1'b0;
    end
  end

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata (din),
    .raddr (rptr),
    .rdata (rd_data)
  );

  assign level     = lvl;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  if (FWFT == int'(FIFO_MODE_FWFT)) begin : g_fwft
    assign dout       = rd_data;
    assign dout_valid = !fifo_empty;
  end else begin : g_std
    logic [FIFO_WIDTH-1:0] dout_q;
    logic                  dv_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        dout_q <= '0;
        dv_q   <= 1'b0;
      end else begin
        dv_q <= rd_ok;
        if (rd_ok) dout_q <= rd_data;
      end
    end

    assign dout       = dout_q;
    assign dout_valid = dv_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n, write_en, read_en, clear_err;
  logic [W-1:0] din;

  logic [W-1:0] s_dout, f_dout;
  logic         s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic         f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [2:0]   s_level, f_level;

  int checks = 0;
  int errors = 0;

  // Reference model: queue contents, sticky flags, std-mode output register.
  logic [W-1:0] q[$];
  bit           m_ovf, m_unf, m_dv;
  logic [W-1:0] m_dout;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .FIFO_WIDTH (W), .FIFO_DEPTH (D), .AF_THRESH (3), .AE_THRESH (1), .FWFT (0)
  ) u_std (
    .clk (clk), .reset_n (reset_n), .write_en (write_en), .din (din),
    .read_en (read_en), .dout (s_dout), .dout_valid (s_dv),
    .fifo_full (s_full), .fifo_empty (s_empty), .almost_full (s_af),
    .almost_empty (s_ae), .level (s_level), .overflow (s_ovf),
    .underflow (s_unf), .clear_err (clear_err)
  );

  sync_fifo_param #(
    .FIFO_WIDTH (W), .FIFO_DEPTH (D), .AF_THRESH (3), .AE_THRESH (1), .FWFT (1)
  ) u_fwft (
    .clk (clk), .reset_n (reset_n), .write_en (write_en), .din (din),
    .read_en (read_en), .dout (f_dout), .dout_valid (f_dv),
    .fifo_full (f_full), .fifo_empty (f_empty), .almost_full (f_af),
    .almost_empty (f_ae), .level (f_level), .overflow (f_ovf),
    .underflow (f_unf), .clear_err (clear_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 0;
    m_unf  = 0;
    m_dv   = 0;
    m_dout = '0;
  endtask

  task automatic model_edge();
    bit           emp, ful, rd, wr;
    logic [W-1:0] head;
    emp  = (q.size() == 0);
    ful  = (q.size() == D);
    rd   = read_en && !emp;
    wr   = write_en && (!ful || rd);
    head = '0;
    if (rd) head = q.pop_front();
    if (wr) q.push_back(din);
    if (write_en && !wr) m_ovf = 1;
    else if (clear_err)  m_ovf = 0;
    if (read_en && emp)  m_unf = 1;
    else if (clear_err)  m_unf = 0;
    m_dv = rd;
    if (rd) m_dout = head;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("s_level", s_level, n);
    chk("f_level", f_level, n);
    chk("s_full",  s_full,  n == D);
    chk("f_full",  f_full,  n == D);
    chk("s_empty", s_empty, n == 0);
    chk("f_empty", f_empty, n == 0);
    chk("s_af",    s_af,    n >= 3);
    chk("f_af",    f_af,    n >= 3);
    chk("s_ae",    s_ae,    n <= 1);
    chk("f_ae",    f_ae,    n <= 1);
    chk("s_ovf",   s_ovf,   m_ovf);
    chk("f_ovf",   f_ovf,   m_ovf);
    chk("s_unf",   s_unf,   m_unf);
    chk("f_unf",   f_unf,   m_unf);
    chk("s_dv",    s_dv,    m_dv);
    chk("s_dout",  s_dout,  m_dout);
    chk("f_dv",    f_dv,    n != 0);
    if (n != 0) chk("f_dout", f_dout, q[0]);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit we, input logic [W-1:0] d, input bit re, input bit ce);
    write_en  = we;
    din       = d;
    read_en   = re;
    clear_err = ce;
    cycle();
  endtask

  initial begin
    logic [W-1:0] exp_seq [4];

    reset_n = 1'b0; write_en = 1'b0; read_en = 1'b0; clear_err = 1'b0; din = '0;
    model_reset();
    #1 check_all();
    @(posedge clk); #1;
    check_all();
    reset_n = 1'b1;

    // Fill to full, then one dropped write.
    drive(1, 8'h11, 0, 0); chk("lvl1", s_level, 1);
    drive(1, 8'h22, 0, 0); chk("af_below", s_af, 0);
    drive(1, 8'h33, 0, 0); chk("af_at3", s_af, 1);
    drive(1, 8'h44, 0, 0); chk("full_at4", s_full, 1); chk("no_ovf", s_ovf, 0);
    drive(1, 8'h55, 0, 0); chk("ovf_set", s_ovf, 1); chk("lvl_drop", s_level, 4);

    // Drain in order; each word valid for one cycle after its read.
    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(0, 8'h00, 1, 0);
      chk("drain_dout", s_dout, exp_seq[i]);
      chk("drain_dv", s_dv, 1);
    end
    drive(0, 8'h00, 0, 0); chk("dv_pulse_end", s_dv, 0);

    // clear_err together with a new underflow: underflow wins, overflow clears.
    drive(0, 8'h00, 1, 1); chk("unf_wins", s_unf, 1); chk("ovf_cleared", s_ovf, 0);
    drive(0, 8'h00, 0, 1); chk("unf_cleared", s_unf, 0);
    drive(0, 8'h00, 1, 0); chk("unf_rd_empty", s_unf, 1); chk("unf_no_dv", s_dv, 0);
    drive(0, 8'h00, 0, 1);
    drive(1, 8'h77, 1, 0); chk("rw_empty_lvl", s_level, 1); chk("rw_empty_unf", s_unf, 1);
    drive(0, 8'h00, 1, 1); chk("rd_77", s_dout, 8'h77);

    // First-word-fall-through visibility.
    drive(1, 8'hA5, 0, 0);
    chk("fwft_nonempty", f_empty, 0); chk("fwft_dv", f_dv, 1); chk("fwft_dout", f_dout, 8'hA5);
    drive(0, 8'h00, 1, 0); chk("fwft_empty_again", f_empty, 1);

    // Simultaneous read and write while full.
    drive(1, 8'h11, 0, 0); drive(1, 8'h22, 0, 0);
    drive(1, 8'h33, 0, 0); drive(1, 8'h44, 0, 0);
    drive(1, 8'h66, 1, 0);
    chk("full_rw_dout", s_dout, 8'h11); chk("full_rw_lvl", s_level, 4); chk("full_rw_ovf", s_ovf, 0);
    exp_seq = '{8'h22, 8'h33, 8'h44, 8'h66};
    for (int i = 0; i < 4; i++) begin
      drive(0, 8'h00, 1, 0);
      chk("drain2_dout", s_dout, exp_seq[i]);
    end

    // Random traffic across many pointer wraps.
    for (int i = 0; i < 60; i++) begin
      drive(($urandom % 10) < 6, W'($urandom), ($urandom % 10) < 5, ($urandom % 8) == 0);
    end

    // Asynchronous reset in the middle of traffic.
    drive(1, 8'h5A, 0, 0);
    drive(1, 8'hC3, 0, 0);
    write_en = 1'b1; read_en = 1'b1; din = 8'h99;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_level", s_level, 0); chk("rst_empty", f_empty, 1);
    cycle();
    write_en = 1'b0; read_en = 1'b0;
    #1 reset_n = 1'b1;
    drive(1, 8'h3C, 0, 0); chk("post_rst_wr", f_dout, 8'h3C);
    for (int i = 0; i < 12; i++) begin
      drive(($urandom % 2) == 1, W'($urandom), ($urandom % 2) == 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
